mem_line_responder: RTL

- Memory-side responder for the 128-bit cache-line request/ready protocol driven by the instruction and data caches.
- Accepts one line read or line write at a time and holds it for a programmable latency.
- Then returns data, or commits the write, with a single-cycle mem_ready pulse.
- Backs the line storage with an internal array; serves as the slave memory in pipelined-CPU integration and cache regression.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/mem_lat_lfsr.sv | 25 ++
 rtl/mem_line_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the cache-line memory responder.
// Used by mem_line_responder and, when MEM_LAT_JITTER_EN is defined, mem_lat_lfsr.
package mem_resp_pkg;

  localparam int LINE_W  = 128;
  localparam int MADDR_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 in 1-based Fibonacci notation map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_lat_lfsr.sv
// 8-bit Fibonacci LFSR supplying 0..3 cycles of extra response latency.
// Present in the build only when MEM_LAT_JITTER_EN is defined.
module mem_lat_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [1:0] extra
);

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Extra latency comes from the value before the advance.
  assign extra = lfsr[1:0];

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side 128-bit line responder: one request at a time, fixed latency, one-cycle mem_ready.
// Optional macro MEM_LAT_JITTER_EN adds 0..3 cycles of LFSR-driven extra latency per request.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int LAT        = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [MADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]  mem_wdata,
  output logic [LINE_W-1:0]  mem_rdata,
  output logic               mem_ready
);

  localparam int CNT_W = 5;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    op_wr, op_wr_nxt;
  logic [DEPTH_LOG2-1:0]   idx, idx_nxt;
  logic [LINE_W-1:0]       wdata_q, wdata_nxt;
  logic                    ready_nxt;
  logic [LINE_W-1:0]       rdata_nxt;
  logic                    accept;
  logic [1:0]              extra;
  logic [CNT_W-1:0]        total;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    unused_addr_hi;
  logic [LINE_W-1:0]       mem_q [DEPTH];

  assign req_idx        = mem_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_addr[MADDR_W-1:DEPTH_LOG2];

`ifdef MEM_LAT_JITTER_EN
  mem_lat_lfsr u_lat_lfsr (
    .clk   (clk),
    .rst_n (proc_reset_n),
    .adv   (accept),
    .extra (extra)
  );
`else
  assign extra = 2'd0;
`endif

  // Cycles from acceptance to mem_ready, minus one; zero means answer right after acceptance.
  assign total = CNT_W'(LAT - 1) + CNT_W'(extra);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    idx_nxt   = idx;
    wdata_nxt = wdata_q;
    ready_nxt = 1'b0;
    rdata_nxt = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          accept    = 1'b1;
          op_wr_nxt = mem_write;
          idx_nxt   = req_idx;
          wdata_nxt = mem_wdata;
          if (total == '0) begin
            state_nxt = ST_RESP;
            ready_nxt = 1'b1;
            if (!mem_write) rdata_nxt = mem_q[req_idx];
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = total - 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // A dropped request abandons the operation even on its final count.
        if (!(mem_read || mem_write)) begin
          state_nxt = ST_IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          if (!op_wr) rdata_nxt = mem_q[idx];
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_wr     <= op_wr_nxt;
      mem_ready <= ready_nxt;
      mem_rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    idx     <= idx_nxt;
    wdata_q <= wdata_nxt;
  end

  // Write commit happens on the edge that ends RESP; reset at that edge cancels it.
  always_ff @(posedge clk) begin
    if (proc_reset_n && state == ST_RESP && op_wr) begin
      mem_q[idx] <= wdata_q;
    end
  end

endmodule
